dmem_responder: RTL and testbench

Data-memory responder servicing load/store requests issued by the pipeline memory stage. It accepts one request at a time over a valid/ready handshake and inserts a configurable number of wait states. It then commits the write or returns read data with a one-cycle response pulse. It is the memory-side end of the memory-stage interface and replaces the zero-latency combinational data memory when wait states are needed.

---
 rtl/dmem_responder.sv | 143 ++++++++++++++
 tb/tb_dmem_responder.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_responder.sv
// Data-memory responder: one outstanding load/store, LATENCY wait states,
// then a single-cycle response carrying read data or an error flag.
module dmem_responder #(
   parameter int DEPTH   = 64,
   parameter int LATENCY = 2
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        req_valid,
   input  logic        req_write,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        req_ready,
   output logic        rsp_valid,
   output logic [31:0] rsp_rdata,
   output logic        rsp_err,
   output logic        busy
);

   localparam int         AW   = $clog2(DEPTH);
   localparam logic [3:0] LAT4 = 4'(LATENCY);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_WAIT,
      ST_RESP
   } state_t;

   state_t      state_reg, state_next;
   logic [3:0]  cnt_reg, cnt_next;
   logic        write_reg;
   logic [31:0] addr_reg;
   logic [31:0] wdata_reg;
   logic        err_reg;
   logic        load_ok_reg;

   logic        capture;
   logic        access;
   logic        acc_write;
   logic [31:0] acc_addr;
   logic [31:0] acc_wdata;
   logic        acc_err;
   logic [AW-1:0] acc_index;
   logic        mem_we;
   logic        mem_re;

   logic [31:0] mem [DEPTH];
   logic [31:0] mem_q;

   // With zero wait states the access happens on the handshake edge itself,
   // so the live request inputs feed the memory instead of the capture regs.
   always_comb begin
      if (state_reg == ST_IDLE) begin
         acc_write = req_write;
         acc_addr  = req_addr;
         acc_wdata = req_wdata;
      end else begin
         acc_write = write_reg;
         acc_addr  = addr_reg;
         acc_wdata = wdata_reg;
      end
   end

   assign acc_index = acc_addr[AW+1:2];
   assign acc_err   = (acc_addr[1:0] != 2'b00) || (|acc_addr[31:AW+2]);
   assign mem_we    = reset && access && acc_write && !acc_err;
   assign mem_re    = reset && access && !acc_write && !acc_err;

   always_comb begin
      state_next = state_reg;
      cnt_next   = cnt_reg;
      capture    = 1'b0;
      access     = 1'b0;
      case (state_reg)
         ST_IDLE: begin
            if (req_valid) begin
               capture  = 1'b1;
               cnt_next = LAT4;
               if (LATENCY == 0) begin
                  state_next = ST_RESP;
                  access     = 1'b1;
               end else begin
                  state_next = ST_WAIT;
               end
            end
         end
         ST_WAIT: begin
            cnt_next = cnt_reg - 4'd1;
            if (cnt_reg == 4'd1) begin
               state_next = ST_RESP;
               access     = 1'b1;
            end
         end
         ST_RESP: begin
            state_next = ST_IDLE;
         end
         default: begin
            state_next = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_reg   <= ST_IDLE;
         cnt_reg     <= 4'd0;
         write_reg   <= 1'b0;
         addr_reg    <= 32'd0;
         wdata_reg   <= 32'd0;
         err_reg     <= 1'b0;
         load_ok_reg <= 1'b0;
      end else begin
         state_reg <= state_next;
         cnt_reg   <= cnt_next;
         if (capture) begin
            write_reg <= req_write;
            addr_reg  <= req_addr;
            wdata_reg <= req_wdata;
         end
         if (access) begin
            err_reg     <= acc_err;
            load_ok_reg <= !acc_write && !acc_err;
         end
      end
   end

   // Storage carries no reset so it maps onto block RAM with a registered read.
   always_ff @(posedge clk) begin
      if (mem_we) begin
         mem[acc_index] <= acc_wdata;
      end
      if (mem_re) begin
         mem_q <= mem[acc_index];
      end
   end

   assign req_ready = reset && (state_reg == ST_IDLE);
   assign rsp_valid = (state_reg == ST_RESP);
   assign busy      = (state_reg != ST_IDLE);
   assign rsp_err   = rsp_valid && err_reg;
   assign rsp_rdata = (rsp_valid && load_ok_reg) ? mem_q : 32'd0;

endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench: two responders (LATENCY 2 and 0) driven by a
// directed table, hand-written reset/hold sequences and random traffic.
module tb_dmem_responder;

   localparam int DEPTH = 64;
   localparam int LAT0  = 2;
   localparam int LAT1  = 0;

   logic        clk = 1'b0;
   logic        reset;
   logic [1:0]  req_valid, req_write, req_ready, rsp_valid, rsp_err, busy;
   logic [31:0] req_addr  [2];
   logic [31:0] req_wdata [2];
   logic [31:0] rsp_rdata [2];

   int n_cmp = 0;
   int n_bad = 0;

   logic [31:0] mem_m   [2][DEPTH];
   bit          known_m [2][DEPTH];

   always #5 clk = ~clk;

   dmem_responder #(.DEPTH(DEPTH), .LATENCY(LAT0)) dut0 (
      .clk(clk), .reset(reset),
      .req_valid(req_valid[0]), .req_write(req_write[0]),
      .req_addr(req_addr[0]), .req_wdata(req_wdata[0]),
      .req_ready(req_ready[0]), .rsp_valid(rsp_valid[0]),
      .rsp_rdata(rsp_rdata[0]), .rsp_err(rsp_err[0]), .busy(busy[0])
   );

   dmem_responder #(.DEPTH(DEPTH), .LATENCY(LAT1)) dut1 (
      .clk(clk), .reset(reset),
      .req_valid(req_valid[1]), .req_write(req_write[1]),
      .req_addr(req_addr[1]), .req_wdata(req_wdata[1]),
      .req_ready(req_ready[1]), .rsp_valid(rsp_valid[1]),
      .rsp_rdata(rsp_rdata[1]), .rsp_err(rsp_err[1]), .busy(busy[1])
   );

   typedef struct {
      int          inst;
      bit          wr;
      logic [31:0] addr;
      logic [31:0] wd;
      bit          err;
      logic [31:0] rd;
   } vec_t;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Reference: plain word-addressed array, error when not aligned or beyond DEPTH words.
   function automatic void model(input int inst, input bit wr, input logic [31:0] addr,
                                 input logic [31:0] wd, output bit err,
                                 output logic [31:0] rd, output bit rd_known);
      int idx;
      idx      = int'(addr / 4) % DEPTH;
      err      = (addr % 4 != 0) || (addr >= 32'(DEPTH * 4));
      rd       = 32'd0;
      rd_known = 1'b1;
      if (!err) begin
         if (wr) begin
            mem_m[inst][idx]   = wd;
            known_m[inst][idx] = 1'b1;
         end else begin
            rd       = mem_m[inst][idx];
            rd_known = known_m[inst][idx];
         end
      end
   endfunction

   // Starts and ends on a falling edge.
   task automatic do_txn(input int inst, input bit wr, input logic [31:0] addr,
                         input logic [31:0] wd, output bit got_err, output logic [31:0] got_rd);
      int lat;
      int n;
      bit seen;
      lat     = (inst == 0) ? LAT0 : LAT1;
      got_err = 1'b0;
      got_rd  = 32'd0;
      n = 0;
      while (req_ready[inst] !== 1'b1 && n < 40) begin
         @(negedge clk);
         n++;
      end
      chk("ready_idle", 32'(req_ready[inst]), 32'd1);
      chk("busy_idle", 32'(busy[inst]), 32'd0);
      req_valid[inst] = 1'b1;
      req_write[inst] = wr;
      req_addr[inst]  = addr;
      req_wdata[inst] = wd;
      @(negedge clk);
      req_valid[inst] = 1'b0;
      req_write[inst] = ~wr;
      req_addr[inst]  = $urandom;
      req_wdata[inst] = $urandom;
      seen = 1'b0;
      for (n = 1; n <= lat + 4 && !seen; n++) begin
         if (n > 1) @(negedge clk);
         if (rsp_valid[inst] === 1'b1) begin
            seen = 1'b1;
            chk("rsp_cycle", 32'(n), 32'(lat + 1));
            chk("busy_resp", 32'(busy[inst]), 32'd1);
            chk("ready_resp", 32'(req_ready[inst]), 32'd0);
            got_err = rsp_err[inst];
            got_rd  = rsp_rdata[inst];
         end else if (n <= lat) begin
            chk("busy_wait", 32'(busy[inst]), 32'd1);
            chk("ready_wait", 32'(req_ready[inst]), 32'd0);
         end
      end
      if (!seen) begin
         n_cmp++;
         n_bad++;
         $display("FAIL rsp_timeout: inst %0d got no rsp_valid within %0d cycles, expected one", inst, lat + 4);
      end
      @(negedge clk);
      chk("rsp_drop", 32'(rsp_valid[inst]), 32'd0);
      chk("rdata_clr", rsp_rdata[inst], 32'd0);
      chk("err_clr", 32'(rsp_err[inst]), 32'd0);
      chk("ready_back", 32'(req_ready[inst]), 32'd1);
      chk("busy_back", 32'(busy[inst]), 32'd0);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      vec_t        tbl [$];
      bit          g_err, m_err, m_known;
      logic [31:0] g_rd, m_rd, a, hb;
      int          inst;

      for (int i = 0; i < 2; i++)
         for (int j = 0; j < DEPTH; j++) begin
            mem_m[i][j]   = 32'd0;
            known_m[i][j] = 1'b0;
         end

      // Reset held with requests pending.
      reset     = 1'b0;
      req_valid = 2'b11;
      req_write = 2'b11;
      for (int i = 0; i < 2; i++) begin
         req_addr[i]  = 32'h10;
         req_wdata[i] = 32'hBAD0BAD0;
      end
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         for (int i = 0; i < 2; i++) begin
            chk("rst_ready", 32'(req_ready[i]), 32'd0);
            chk("rst_rsp_valid", 32'(rsp_valid[i]), 32'd0);
            chk("rst_rdata", rsp_rdata[i], 32'd0);
            chk("rst_err", 32'(rsp_err[i]), 32'd0);
            chk("rst_busy", 32'(busy[i]), 32'd0);
         end
      end
      reset     = 1'b1;
      req_valid = 2'b00;
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
         chk("post_rst_ready", 32'(req_ready[i]), 32'd1);
         chk("post_rst_busy", 32'(busy[i]), 32'd0);
      end

      tbl.push_back('{0, 1'b1, 32'h10,       32'hDEADBEEF, 1'b0, 32'h0});
      tbl.push_back('{0, 1'b0, 32'h10,       32'h0,        1'b0, 32'hDEADBEEF});
      tbl.push_back('{0, 1'b0, 32'h12,       32'h0,        1'b1, 32'h0});
      tbl.push_back('{0, 1'b0, 32'h100,      32'h0,        1'b1, 32'h0});
      tbl.push_back('{0, 1'b1, 32'h12,       32'h1,        1'b1, 32'h0});
      tbl.push_back('{0, 1'b0, 32'h10,       32'h0,        1'b0, 32'hDEADBEEF});
      tbl.push_back('{0, 1'b1, 32'h20,       32'h11,       1'b0, 32'h0});
      tbl.push_back('{0, 1'b1, 32'h24,       32'h55,       1'b0, 32'h0});
      tbl.push_back('{0, 1'b1, 32'h30,       32'hCAFE0000, 1'b0, 32'h0});
      tbl.push_back('{1, 1'b1, 32'h04,       32'h5A,       1'b0, 32'h0});
      tbl.push_back('{1, 1'b0, 32'h04,       32'h0,        1'b0, 32'h5A});
      tbl.push_back('{1, 1'b0, 32'h80000000, 32'h0,        1'b1, 32'h0});
      tbl.push_back('{1, 1'b1, 32'hFC,       32'h13579BDF, 1'b0, 32'h0});
      tbl.push_back('{1, 1'b0, 32'hFC,       32'h0,        1'b0, 32'h13579BDF});

      foreach (tbl[k]) begin
         do_txn(tbl[k].inst, tbl[k].wr, tbl[k].addr, tbl[k].wd, g_err, g_rd);
         model(tbl[k].inst, tbl[k].wr, tbl[k].addr, tbl[k].wd, m_err, m_rd, m_known);
         chk("tbl_err", 32'(g_err), 32'(tbl[k].err));
         chk("tbl_rdata", g_rd, tbl[k].rd);
         $display("table %0d: inst=%0d %s addr=0x%08h err=%0d rdata=0x%08h",
                  k, tbl[k].inst, tbl[k].wr ? "ST" : "LD", tbl[k].addr, g_err, g_rd);
      end

      // req_valid held high with changing inputs while the store is outstanding.
      req_valid[0] = 1'b1;
      req_write[0] = 1'b1;
      req_addr[0]  = 32'h30;
      req_wdata[0] = 32'h1234;
      @(negedge clk);
      req_write[0] = 1'b0;
      req_addr[0]  = 32'h34;
      req_wdata[0] = 32'hFFFF;
      for (int n = 1; n <= 3; n++) begin
         if (n > 1) @(negedge clk);
         chk("hold_ready", 32'(req_ready[0]), 32'd0);
         chk("hold_rsp_valid", 32'(rsp_valid[0]), (n == 3) ? 32'd1 : 32'd0);
      end
      chk("hold_err", 32'(rsp_err[0]), 32'd0);
      chk("hold_rdata", rsp_rdata[0], 32'd0);
      req_valid[0] = 1'b0;
      @(negedge clk);
      chk("hold_ready_back", 32'(req_ready[0]), 32'd1);
      model(0, 1'b1, 32'h30, 32'h1234, m_err, m_rd, m_known);
      do_txn(0, 1'b0, 32'h30, 32'h0, g_err, g_rd);
      chk("hold_capture", g_rd, 32'h1234);
      $display("hold: inst=0 LD addr=0x00000030 rdata=0x%08h", g_rd);

      // Reset in the first wait cycle aborts a store.
      req_valid[0] = 1'b1;
      req_write[0] = 1'b1;
      req_addr[0]  = 32'h20;
      req_wdata[0] = 32'h77;
      @(negedge clk);
      req_valid[0] = 1'b0;
      reset        = 1'b0;
      @(negedge clk);
      chk("abort_rsp_valid", 32'(rsp_valid[0]), 32'd0);
      chk("abort_busy", 32'(busy[0]), 32'd0);
      reset = 1'b1;
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         chk("abort_quiet", 32'(rsp_valid[0]), 32'd0);
      end
      do_txn(0, 1'b0, 32'h20, 32'h0, g_err, g_rd);
      chk("abort_nocommit", g_rd, 32'h11);
      $display("abort wait: inst=0 LD addr=0x00000020 rdata=0x%08h", g_rd);

      // Reset on the edge that would enter the response state.
      req_valid[0] = 1'b1;
      req_write[0] = 1'b1;
      req_addr[0]  = 32'h24;
      req_wdata[0] = 32'h99;
      @(negedge clk);
      req_valid[0] = 1'b0;
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      chk("abort2_rsp_valid", 32'(rsp_valid[0]), 32'd0);
      chk("abort2_busy", 32'(busy[0]), 32'd0);
      reset = 1'b1;
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         chk("abort2_quiet", 32'(rsp_valid[0]), 32'd0);
      end
      do_txn(0, 1'b0, 32'h24, 32'h0, g_err, g_rd);
      chk("abort2_nocommit", g_rd, 32'h55);
      $display("abort resp edge: inst=0 LD addr=0x00000024 rdata=0x%08h", g_rd);

      // Random traffic against the reference model.
      for (int t = 0; t < 120; t++) begin
         bit wr;
         int kind;
         inst = int'($urandom_range(0, 1));
         wr   = 1'($urandom_range(0, 1));
         kind = int'($urandom_range(0, 9));
         if (kind == 0) begin
            a = 32'($urandom_range(0, DEPTH - 1) * 4 + $urandom_range(1, 3));
         end else if (kind == 1) begin
            hb = 32'h100 << $urandom_range(0, 23);
            a  = ($urandom & 32'hFFFFFFFC) | hb;
         end else begin
            a = 32'($urandom_range(0, DEPTH - 1) * 4);
         end
         repeat ($urandom_range(0, 2)) @(negedge clk);
         do_txn(inst, wr, a, $urandom, g_err, g_rd);
         model(inst, wr, a, req_wdata_last(inst), m_err, m_rd, m_known);
         chk("rand_err", 32'(g_err), 32'(m_err));
         if (m_known) chk("rand_rdata", g_rd, m_rd);
         $display("random %0d: inst=%0d %s addr=0x%08h err=%0d rdata=0x%08h",
                  t, inst, wr ? "ST" : "LD", a, g_err, g_rd);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   // Store data of the most recent handshake, recorded at the accepting edge.
   logic [31:0] last_wd [2];
   always @(posedge clk) begin
      for (int i = 0; i < 2; i++)
         if (req_valid[i] && req_ready[i]) last_wd[i] <= req_wdata[i];
   end

   function automatic logic [31:0] req_wdata_last(input int inst);
      return last_wd[inst];
   endfunction

endmodule
